decode_ctrl_pipe: RTL and testbench

Registered, handshaked instruction-decode stage that generalises the single-cycle combinational controller. It accepts one 32-bit instruction per cycle through a valid/ready handshake and decodes the full ISA: R-type, I-type, J-type, branches, mul/div and exceptions. It presents a registered control word plus register-field selects to the execute stage. It also holds off new instructions for a parametrised number of cycles after issuing a multicycle mul/div.

---
 rtl/decode_ctrl_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// Registered valid/ready instruction-decode stage: decodes one 32-bit insn per cycle into a
// control word for execute and stalls intake while a multicycle mul/div is running.
module decode_ctrl_pipe #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] insn,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic        alu_in_b,
    output logic        dm_we,
    output logic        rf_we,
    output logic [1:0]  rf_wd_sel,
    output logic [1:0]  branch,
    output logic [1:0]  jump,
    output logic        md_start,
    output logic        md_is_div,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [31:0] imm,
    output logic        illegal
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    typedef struct packed {
        logic [4:0]  alu_op;
        logic        alu_in_b;
        logic        dm_we;
        logic        rf_we;
        logic [1:0]  rf_wd_sel;
        logic [1:0]  branch;
        logic [1:0]  jump;
        logic        md_start;
        logic        md_is_div;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MD_BUSY = 1'b1} state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_valid_r;
    ctrl_t            word_r;
    ctrl_t            dec_s;
    logic [4:0]       opcode_s;
    logic [4:0]       alu_fn_s;
    logic             load_s;
    logic             xfer_s;

    assign opcode_s = insn[31:27];
    assign alu_fn_s = insn[6:2];
    assign in_ready = ~reset & (state_r == ST_IDLE) & (~out_valid_r | out_ready);
    assign load_s   = in_valid & in_ready;
    // A flushed word is dropped, so it never counts as handed to execute.
    assign xfer_s   = out_valid_r & out_ready & ~flush;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        dec_s        = '0;
        dec_s.rd     = insn[26:22];
        dec_s.rs     = insn[21:17];
        dec_s.rt     = insn[16:12];
        dec_s.imm    = {{15{insn[16]}}, insn[16:0]};
        case (opcode_s)
            OP_RTYPE: begin
                case (alu_fn_s)
                    5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101: begin
                        dec_s.rf_we  = 1'b1;
                        dec_s.alu_op = alu_fn_s;
                    end
                    5'b00110, 5'b00111: begin
                        dec_s.md_start  = 1'b1;
                        dec_s.md_is_div = insn[2];
                        dec_s.rf_we     = 1'b1;
                        dec_s.rf_wd_sel = 2'd3;
                    end
                    default: dec_s.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW: begin
                dec_s.alu_op    = ALU_ADD;
                dec_s.alu_in_b  = 1'b1;
                dec_s.rf_we     = 1'b1;
                dec_s.rf_wd_sel = (opcode_s == OP_LW) ? 2'd1 : 2'd0;
            end
            OP_SW: begin
                dec_s.alu_op   = ALU_ADD;
                dec_s.alu_in_b = 1'b1;
                dec_s.dm_we    = 1'b1;
                dec_s.rt       = insn[26:22];
            end
            OP_BNE, OP_BLT: begin
                dec_s.alu_op = ALU_SUB;
                dec_s.branch = (opcode_s == OP_BNE) ? 2'd1 : 2'd2;
                dec_s.rs     = insn[26:22];
                dec_s.rt     = insn[21:17];
            end
            OP_BEX: begin
                dec_s.branch = 2'd3;
                dec_s.rs     = 5'd30;
                dec_s.imm    = {5'd0, insn[26:0]};
            end
            OP_J: begin
                dec_s.jump = 2'd1;
                dec_s.imm  = {5'd0, insn[26:0]};
            end
            OP_JAL: begin
                dec_s.jump      = 2'd1;
                dec_s.rf_we     = 1'b1;
                dec_s.rf_wd_sel = 2'd2;
                dec_s.rd        = 5'd31;
                dec_s.imm       = {5'd0, insn[26:0]};
            end
            OP_JR: begin
                dec_s.jump = 2'd2;
                dec_s.rs   = insn[26:22];
                dec_s.imm  = {5'd0, insn[26:0]};
            end
            OP_SETX: begin
                dec_s.rf_we    = 1'b1;
                dec_s.rd       = 5'd30;
                dec_s.rs       = 5'd0;
                dec_s.alu_op   = ALU_ADD;
                dec_s.alu_in_b = 1'b1;
                dec_s.imm      = {5'd0, insn[26:0]};
            end
            default: dec_s.illegal = 1'b1;
        endcase
    end

    // Output holding register; flush outranks a same-cycle accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            word_r      <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            word_r      <= dec_s;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Mul/div busy FSM; a mul/div handed out while already busy restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else if (xfer_s && word_r.md_start) begin
            state_r <= ST_MD_BUSY;
            cnt_r   <= CNT_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_MD_BUSY: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign alu_op    = word_r.alu_op;
    assign alu_in_b  = word_r.alu_in_b;
    assign dm_we     = word_r.dm_we;
    assign rf_we     = word_r.rf_we;
    assign rf_wd_sel = word_r.rf_wd_sel;
    assign branch    = word_r.branch;
    assign jump      = word_r.jump;
    assign md_start  = word_r.md_start;
    assign md_is_div = word_r.md_is_div;
    assign rd        = word_r.rd;
    assign rs        = word_r.rs;
    assign rt        = word_r.rt;
    assign imm       = word_r.imm;
    assign illegal   = word_r.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed scenarios plus a randomized run
// against an ISA-level decode table and a cycle-level handshake/busy model.
module tb_decode_ctrl_pipe;

    localparam int LAT = 4;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic        alu_in_b;
        logic        dm_we;
        logic        rf_we;
        logic [1:0]  rf_wd_sel;
        logic [1:0]  branch;
        logic [1:0]  jump;
        logic        md_start;
        logic        md_is_div;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    logic        clock, reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] insn, imm;
    logic [4:0]  alu_op, rd, rs, rt;
    logic        alu_in_b, dm_we, rf_we, md_start, md_is_div, illegal;
    logic [1:0]  rf_wd_sel, branch, jump;
    ctrl_t       dut_w;

    int    checks = 0;
    int    errors = 0;
    bit    m_valid;
    ctrl_t m_word;
    int    busy_left;

    decode_ctrl_pipe #(.MD_LATENCY(LAT), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .insn(insn),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_in_b(alu_in_b), .dm_we(dm_we), .rf_we(rf_we), .rf_wd_sel(rf_wd_sel),
        .branch(branch), .jump(jump), .md_start(md_start), .md_is_div(md_is_div),
        .rd(rd), .rs(rs), .rt(rt), .imm(imm), .illegal(illegal)
    );

    assign dut_w = {alu_op, alu_in_b, dm_we, rf_we, rf_wd_sel, branch, jump, md_start,
                    md_is_div, rd, rs, rt, imm, illegal};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] enc_r(input int fn);
        logic [4:0] f;
        f = fn[4:0];
        return {5'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), f, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input int op);
        logic [4:0] o;
        o = op[4:0];
        return {o, 27'($urandom)};
    endfunction

    // ISA table: what execute should see for a given instruction word.
    function automatic ctrl_t ref_decode(input logic [31:0] w);
        ctrl_t c;
        int op, fn;
        op = int'(w[31:27]);
        fn = int'(w[6:2]);
        c = '0;
        c.rd = w[26:22];
        c.rs = w[21:17];
        c.rt = w[16:12];
        c.imm = 32'($signed(w[16:0]));
        if (op == 1 || op == 3 || op == 4 || op == 21 || op == 22) c.imm = 32'(w[26:0]);
        if (op == 0 && fn <= 5) begin
            c.rf_we = 1'b1; c.alu_op = 5'(fn);
        end else if (op == 0 && (fn == 6 || fn == 7)) begin
            c.md_start = 1'b1; c.md_is_div = (fn == 7); c.rf_we = 1'b1; c.rf_wd_sel = 2'd3;
        end else if (op == 5 || op == 8) begin
            c.alu_in_b = 1'b1; c.rf_we = 1'b1; c.rf_wd_sel = (op == 8) ? 2'd1 : 2'd0;
        end else if (op == 7) begin
            c.alu_in_b = 1'b1; c.dm_we = 1'b1; c.rt = w[26:22];
        end else if (op == 2 || op == 6) begin
            c.alu_op = 5'd1; c.branch = (op == 2) ? 2'd1 : 2'd2;
            c.rs = w[26:22]; c.rt = w[21:17];
        end else if (op == 22) begin
            c.branch = 2'd3; c.rs = 5'd30;
        end else if (op == 1) begin
            c.jump = 2'd1;
        end else if (op == 3) begin
            c.jump = 2'd1; c.rf_we = 1'b1; c.rf_wd_sel = 2'd2; c.rd = 5'd31;
        end else if (op == 4) begin
            c.jump = 2'd2; c.rs = w[26:22];
        end else if (op == 21) begin
            c.rf_we = 1'b1; c.rd = 5'd30; c.rs = 5'd0; c.alu_in_b = 1'b1;
        end else begin
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    function automatic bit exp_ready();
        return !reset && busy_left == 0 && (!m_valid || out_ready);
    endfunction

    // Advance the reference model with the current inputs, then let the clock edge happen.
    task automatic tick();
        bit rdy, xfer;
        rdy  = exp_ready();
        xfer = m_valid && out_ready && !flush;
        if (reset) begin
            m_valid = 1'b0; m_word = '0; busy_left = 0;
        end else begin
            if (xfer && m_word.md_start) busy_left = LAT;
            else if (busy_left > 0) busy_left--;
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin m_valid = 1'b1; m_word = ref_decode(insn); end
            else if (xfer) m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; insn = 32'd0;
        m_valid = 1'b0; m_word = '0; busy_left = 0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || dut_w !== '0) begin
            errors++; $display("FAIL reset_state out_valid=%b word=%h expected 0/0", out_valid, dut_w);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_alu_stream();
        logic [31:0] seq [9];
        for (int i = 0; i < 6; i++) seq[i] = enc_r(i);
        seq[6] = enc_i(5); seq[7] = enc_i(8); seq[8] = enc_i(7);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            insn = seq[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d] got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || dut_w !== ref_decode(seq[i])) begin
                errors++;
                $display("FAIL stream_word[%0d] valid=%b word=%h expected 1/%h", i, out_valid, dut_w, ref_decode(seq[i]));
            end
            if (i < 6) begin
                checks++;
                if (alu_op !== 5'(i) || rf_we !== 1'b1) begin
                    errors++; $display("FAIL stream_alu[%0d] alu_op=%b rf_we=%b expected %0d/1", i, alu_op, rf_we, i);
                end
            end
            if (i == 7) begin
                checks++;
                if (rf_wd_sel !== 2'd1 || alu_in_b !== 1'b1) begin
                    errors++; $display("FAIL lw_wd_sel got %0d/%b expected 1/1", rf_wd_sel, alu_in_b);
                end
            end
            if (i == 8) begin
                checks++;
                if (dm_we !== 1'b1 || rf_we !== 1'b0 || rt !== seq[i][26:22]) begin
                    errors++; $display("FAIL sw_ctrl dm_we=%b rf_we=%b rt=%0d expected 1/0/%0d", dm_we, rf_we, rt, seq[i][26:22]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_jumps();
        out_ready = 1'b1; in_valid = 1'b1;
        insn = enc_i(3);
        tick();
        checks++;
        if (rd !== 5'd31 || rf_wd_sel !== 2'd2 || jump !== 2'd1 || rf_we !== 1'b1) begin
            errors++; $display("FAIL jal rd=%0d sel=%0d jump=%0d we=%b expected 31/2/1/1", rd, rf_wd_sel, jump, rf_we);
        end
        insn = enc_i(22);
        tick();
        checks++;
        if (rs !== 5'd30 || branch !== 2'd3 || rf_we !== 1'b0) begin
            errors++; $display("FAIL bex rs=%0d branch=%0d we=%b expected 30/3/0", rs, branch, rf_we);
        end
        insn = {5'b10101, 27'h0000ABC};
        tick();
        checks++;
        if (rd !== 5'd30 || imm !== 32'h0000_0ABC || rf_we !== 1'b1 || alu_in_b !== 1'b1 || rs !== 5'd0) begin
            errors++; $display("FAIL setx rd=%0d imm=%h we=%b rs=%0d expected 30/00000abc/1/0", rd, imm, rf_we, rs);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul_stall();
        int n;
        out_ready = 1'b1; in_valid = 1'b1; insn = enc_r(6);
        tick();
        checks++;
        if (out_valid !== 1'b1 || md_start !== 1'b1 || md_is_div !== 1'b0 || rf_wd_sel !== 2'd3) begin
            errors++; $display("FAIL mul_word v=%b start=%b div=%b sel=%0d expected 1/1/0/3", out_valid, md_start, md_is_div, rf_wd_sel);
        end
        in_valid = 1'b0;
        tick();
        insn = enc_r(0); in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== LAT) begin
            errors++; $display("FAIL mul_stall_len got %0d cycles expected %0d", n, LAT);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_op !== 5'd0 || rf_we !== 1'b1 || md_start !== 1'b0) begin
            errors++; $display("FAIL add_after_mul v=%b op=%0d we=%b start=%b expected 1/0/1/0", out_valid, alu_op, rf_we, md_start);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        a = enc_i(5); b = enc_r(1);
        out_ready = 1'b0; in_valid = 1'b1; insn = a;
        tick();
        insn = b;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_w !== ref_decode(a)) begin
                errors++; $display("FAIL hold[%0d] rdy=%b v=%b word=%h expected 0/1/%h", k, in_ready, out_valid, dut_w, ref_decode(a));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || dut_w !== ref_decode(b)) begin
            errors++; $display("FAIL release_word v=%b word=%h expected 1/%h", out_valid, dut_w, ref_decode(b));
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; insn = enc_r(6);
        tick();
        insn = enc_r(0); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL flush_held[%0d] v=%b rdy=%b expected 0/1", k, out_valid, in_ready);
            end
            tick();
        end
        in_valid = 1'b1; flush = 1'b1; insn = enc_r(2);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_vs_accept v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w [2];
        w[0] = {5'b11111, 27'($urandom)};
        w[1] = enc_r(10);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; insn = w[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || rf_we !== 1'b0 || dm_we !== 1'b0 || md_start !== 1'b0) begin
                errors++;
                $display("FAIL illegal[%0d] v=%b ill=%b rf=%b dm=%b md=%b expected 1/1/0/0/0", i, out_valid, illegal, rf_we, dm_we, md_start);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        out_ready = 1'b1; in_valid = 1'b1; insn = enc_r(7);
        tick();
        checks++;
        if (md_is_div !== 1'b1 || md_start !== 1'b1) begin
            errors++; $display("FAIL div_word div=%b start=%b expected 1/1", md_is_div, md_start);
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL busy_ready got %b expected 0", in_ready);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL in_reset_ready got %b expected 0", in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL after_busy_reset rdy=%b v=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) insn = $urandom;
            else if ($urandom_range(0, 2) == 0) insn = enc_r($urandom_range(0, 9));
            else insn = enc_i(ops[$urandom_range(0, 10)]);
            #1;
            checks++;
            if (in_ready !== exp_ready() || out_valid !== m_valid) begin
                errors++; $display("FAIL rand_hs[%0d] rdy=%b v=%b expected %b/%b", c, in_ready, out_valid, exp_ready(), m_valid);
            end
            if (m_valid) begin
                checks++;
                if (dut_w !== m_word) begin
                    errors++; $display("FAIL rand_word[%0d] got %h expected %h", c, dut_w, m_word);
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_jumps();
        test_mul_stall();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
